// File: rtl/lsu_multicycle_if.sv
// Word-aligned req/gnt/rvalid data bus between the load/store unit and memory.
interface lsu_multicycle_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              mem_err;

  modport master (
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/lsu_multicycle.sv
// Multicycle load/store unit: lane steering, sign/zero extension, per-beat response timeout.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses into two aligned beats.
module lsu_multicycle #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              exc,
  output logic [31:0]       exc_cause,
  output logic [ADDR_W-1:0] exc_tval,
  lsu_multicycle_if.master  mem
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
  localparam logic [31:0] CAUSE_LD_MISALIGN = 32'd4;
  localparam logic [31:0] CAUSE_LD_FAULT    = 32'd5;
  localparam logic [31:0] CAUSE_ST_MISALIGN = 32'd6;
  localparam logic [31:0] CAUSE_ST_FAULT    = 32'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0, REQ0 = 3'd1, RSP0 = 3'd2, REQ1 = 3'd3, RSP1 = 3'd4, FIN = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              exc_q, exc_d;
  logic [31:0]       cause_q, cause_d;
  logic [ADDR_W-1:0] tval_q, tval_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       mwdata_q, mwdata_d;

  logic [3:0]  mask_c, be_lo_c;
  logic [31:0] wd_lo_c, raw_c;
  logic [4:0]  sh_c;
  logic        mis_c, timeout_c, fault_c;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        mis_q, mis_d;
  logic [3:0]  be_hi_q, be_hi_d, be_hi_c;
  logic [31:0] wd_hi_q, wd_hi_d, wd_hi_c, rd0_q, rd0_d;

  assign be_hi_c = mask_c >> (3'd4 - {1'b0, addr[1:0]});
  assign wd_hi_c = wdata >> (6'd32 - {1'b0, addr[1:0], 3'b000});
`endif

  // Lane mask of the access size, before shifting to the byte offset.
  always_comb begin
    case (op[2:1])
      2'b11:   mask_c = 4'b0001;
      2'b01:   mask_c = 4'b0011;
      2'b10:   mask_c = 4'b1111;
      default: mask_c = 4'b0000;
    endcase
  end

  assign mis_c     = ((op[2:1] == 2'b01) && (addr[1:0] == 2'b11)) ||
                     ((op[2:1] == 2'b10) && (addr[1:0] != 2'b00));
  assign be_lo_c   = mask_c << addr[1:0];
  assign wd_lo_c   = wdata << {addr[1:0], 3'b000};
  assign sh_c      = {addr_q[1:0], 3'b000};
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
  assign fault_c   = mem.mem_rvalid ? mem.mem_err : timeout_c;

  function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [2:0] o);
    case (o[2:1])
      2'b11:   return o[0] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   return o[0] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    exc_d    = exc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    maddr_d  = maddr_q;
    we_d     = we_q;
    be_d     = be_q;
    mwdata_d = mwdata_q;
    raw_c    = '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    mis_d   = mis_q;
    be_hi_d = be_hi_q;
    wd_hi_d = wd_hi_q;
    rd0_d   = rd0_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        addr_d  = addr;
        rdata_d = '0;
        exc_d   = 1'b0;
        cause_d = '0;
        tval_d  = '0;
        if (op == 4'b0000) begin
          state_d = FIN;
        end else if (op[2:1] == 2'b00) begin
          state_d = FIN;
          exc_d   = 1'b1;
          cause_d = CAUSE_ILLEGAL;
          tval_d  = addr;
`ifndef LSU_MISALIGNED_SPLIT_EN
        end else if (mis_c) begin
          state_d = FIN;
          exc_d   = 1'b1;
          cause_d = op[3] ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
          tval_d  = addr;
`endif
        end else begin
          state_d  = REQ0;
          maddr_d  = {addr[ADDR_W-1:2], 2'b00};
          we_d     = ~op[3];
          be_d     = be_lo_c;
          mwdata_d = wd_lo_c;
`ifdef LSU_MISALIGNED_SPLIT_EN
          mis_d   = mis_c;
          be_hi_d = be_hi_c;
          wd_hi_d = wd_hi_c;
`endif
        end
      end
      REQ0, REQ1: if (mem.mem_gnt) begin
        state_d = (state_q == REQ1) ? RSP1 : RSP0;
        cnt_d   = '0;
      end
      RSP0, RSP1: begin
        if (fault_c) begin
          state_d = FIN;
          exc_d   = 1'b1;
          cause_d = op_q[3] ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
          tval_d  = addr_q;
        end else if (mem.mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if ((state_q == RSP0) && mis_q) begin
            rd0_d    = mem.mem_rdata;
            state_d  = REQ1;
            maddr_d  = maddr_q + ADDR_W'(4);
            be_d     = be_hi_q;
            mwdata_d = wd_hi_q;
          end else begin
            raw_c   = (state_q == RSP1) ? 32'({mem.mem_rdata, rd0_q} >> sh_c)
                                        : mem.mem_rdata >> sh_c;
            state_d = FIN;
            if (op_q[3]) rdata_d = load_ext(raw_c, op_q[2:0]);
          end
`else
          raw_c   = mem.mem_rdata >> sh_c;
          state_d = FIN;
          if (op_q[3]) rdata_d = load_ext(raw_c, op_q[2:0]);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
    req_d  = (state_d == REQ0) || (state_d == REQ1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      exc_q    <= 1'b0;
      cause_q  <= '0;
      tval_q   <= '0;
      req_q    <= 1'b0;
      maddr_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      mwdata_q <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      mis_q    <= 1'b0;
      be_hi_q  <= '0;
      wd_hi_q  <= '0;
      rd0_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      exc_q    <= exc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      req_q    <= req_d;
      maddr_q  <= maddr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      mwdata_q <= mwdata_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      mis_q    <= mis_d;
      be_hi_q  <= be_hi_d;
      wd_hi_q  <= wd_hi_d;
      rd0_q    <= rd0_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign exc           = exc_q;
  assign exc_cause     = cause_q;
  assign exc_tval      = tval_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_lsu_multicycle.sv
// Scoreboard bench for lsu_multicycle: expected beats/results queued at stimulus, popped on bus grant and done.
module tb_lsu_multicycle;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 4;
  localparam logic [3:0] LW = 4'b1100, LH = 4'b1010, LB = 4'b1110, LBU = 4'b1111;
  localparam logic [3:0] SW = 4'b0100, SB = 4'b0110;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [31:0] cause;
    logic [31:0] tval;
    int          lat;
  } res_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, exc;
  logic [31:0] rdata, exc_cause, exc_tval;
  logic        gnt_en = 1'b1, resp_en = 1'b1, rvalid = 1'b0, rerr = 1'b0, granted = 1'b0;
  logic [31:0] rresp = '0;
  logic [32:0] rtmp;
  int          checks = 0, errors = 0, cyc = 0, start_cyc = 0;

  beat_t       beat_q[$];
  res_t        res_q[$];
  logic [32:0] resp_q[$];

  lsu_multicycle_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.mem_gnt    = bus.mem_req & gnt_en;
  assign bus.mem_rvalid = rvalid;
  assign bus.mem_rdata  = rresp;
  assign bus.mem_err    = rerr;

  lsu_multicycle #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .exc(exc), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .mem(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    beat_q.push_back('{a, be, we, wd});
  endtask

  task automatic exp_res(input logic [31:0] rd, input logic e, input logic [31:0] c, input logic [31:0] tv, input int lat);
    res_q.push_back('{rd, e, c, tv, lat});
  endtask

  task automatic resp(input logic err, input logic [31:0] d);
    resp_q.push_back({err, d});
  endtask

  // Issue one request, optionally holding start high while busy, then wait for its result.
  task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd, input int hold);
    int n;
    @(posedge clk); #1;
    op = o; addr = a; wdata = wd; start = 1'b1; start_cyc = cyc;
    repeat (hold) begin @(posedge clk); #1; end
    start = 1'b0;
    n = 0;
    while (res_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    check("done_wait", 64'(res_q.size()), 64'd0);
    check("beats_left", 64'(beat_q.size()), 64'd0);
    res_q.delete(); beat_q.delete(); resp_q.delete();
  endtask

  // Memory model: same-cycle grant, response one cycle after grant.
  initial forever begin
    @(negedge clk);
    granted = bus.mem_req && bus.mem_gnt && rst_n;
    @(posedge clk); #1;
    if (granted && resp_en) begin
      if (resp_q.size() != 0) begin
        rtmp = resp_q.pop_front();
        rerr = rtmp[32]; rresp = rtmp[31:0];
      end else begin
        rerr = 1'b0; rresp = '0;
      end
      rvalid = 1'b1;
    end else begin
      rvalid = 1'b0; rerr = 1'b0;
    end
  end

  // Bus beat and completion monitors.
  always @(negedge clk) begin
    beat_t b;
    res_t  r;
    if (rst_n && bus.mem_req && bus.mem_gnt) begin
      if (beat_q.size() == 0) check("unexpected_req", 64'(bus.mem_req), 64'd0);
      else begin
        b = beat_q.pop_front();
        check("mem_addr", 64'(bus.mem_addr), 64'(b.addr));
        check("mem_be", 64'(bus.mem_be), 64'(b.be));
        check("mem_we", 64'(bus.mem_we), 64'(b.we));
        check("mem_wdata", 64'(bus.mem_wdata), 64'(b.wd));
      end
    end
    if (rst_n && done) begin
      if (res_q.size() == 0) check("unexpected_done", 64'(done), 64'd0);
      else begin
        r = res_q.pop_front();
        check("latency", 64'(cyc - start_cyc), 64'(r.lat));
        check("busy_at_done", 64'(busy), 64'd1);
        check("rdata", 64'(rdata), 64'(r.rdata));
        check("exc", 64'(exc), 64'(r.exc));
        if (r.exc) begin
          check("exc_cause", 64'(exc_cause), 64'(r.cause));
          check("exc_tval", 64'(exc_tval), 64'(r.tval));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_exc", 64'(exc), 64'd0);
    check("rst_cause", 64'(exc_cause), 64'd0);
    rst_n = 1'b1;

    // Aligned loads and stores; start held high while busy must be ignored.
    exp_beat(32'h100, 4'b1111, 1'b0, 32'h0); resp(1'b0, 32'hDEADBEEF);
    exp_res(32'hDEADBEEF, 1'b0, 0, 0, 3);
    run(LW, 32'h100, 32'h0, 3);

    exp_beat(32'h100, 4'b1000, 1'b0, 32'h0); resp(1'b0, 32'h80FFFFFF);
    exp_res(32'hFFFFFF80, 1'b0, 0, 0, 3);
    run(LB, 32'h103, 32'h0, 1);

    exp_beat(32'h100, 4'b1000, 1'b0, 32'h0); resp(1'b0, 32'h80FFFFFF);
    exp_res(32'h00000080, 1'b0, 0, 0, 3);
    run(LBU, 32'h103, 32'h0, 1);

    exp_beat(32'h100, 4'b1100, 1'b0, 32'h0); resp(1'b0, 32'h80011234);
    exp_res(32'hFFFF8001, 1'b0, 0, 0, 3);
    run(LH, 32'h102, 32'h0, 1);

    exp_beat(32'h200, 4'b0100, 1'b1, 32'h00AB0000);
    exp_res(32'h0, 1'b0, 0, 0, 3);
    run(SB, 32'h202, 32'h000000AB, 1);

    // Misaligned accesses: split into two beats or rejected.
`ifdef LSU_MISALIGNED_SPLIT_EN
    exp_beat(32'h200, 4'b1110, 1'b1, 32'h22334400);
    exp_beat(32'h204, 4'b0001, 1'b1, 32'h00000011);
    exp_res(32'h0, 1'b0, 0, 0, 5);
`else
    exp_res(32'h0, 1'b1, 32'd6, 32'h201, 1);
`endif
    run(SW, 32'h201, 32'h11223344, 1);

`ifdef LSU_MISALIGNED_SPLIT_EN
    exp_beat(32'h100, 4'b1100, 1'b0, 32'h0); resp(1'b0, 32'h77881122);
    exp_beat(32'h104, 4'b0011, 1'b0, 32'h0); resp(1'b0, 32'h5566AABB);
    exp_res(32'hAABB7788, 1'b0, 0, 0, 5);
`else
    exp_res(32'h0, 1'b1, 32'd4, 32'h102, 1);
`endif
    run(LW, 32'h102, 32'h0, 1);

`ifdef LSU_MISALIGNED_SPLIT_EN
    exp_beat(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0); resp(1'b0, 32'h12000000);
    exp_beat(32'h00000000, 4'b0001, 1'b0, 32'h0); resp(1'b0, 32'h000000B4);
    exp_res(32'hFFFFB412, 1'b0, 0, 0, 5);
`else
    exp_res(32'h0, 1'b1, 32'd4, 32'hFFFFFFFF, 1);
`endif
    run(LH, 32'hFFFFFFFF, 32'h0, 1);

    // Bus errors, timeout, NOP and illegal encodings.
    exp_beat(32'h300, 4'b1111, 1'b0, 32'h0); resp(1'b1, 32'h0);
    exp_res(32'h0, 1'b1, 32'd5, 32'h300, 3);
    run(LW, 32'h300, 32'h0, 1);

    exp_beat(32'h304, 4'b1111, 1'b1, 32'hCAFEF00D); resp(1'b1, 32'h0);
    exp_res(32'h0, 1'b1, 32'd7, 32'h304, 3);
    run(SW, 32'h304, 32'hCAFEF00D, 1);

    resp_en = 1'b0;
    exp_beat(32'h10, 4'b0011, 1'b0, 32'h0);
    exp_res(32'h0, 1'b1, 32'd5, 32'h10, 7);
    run(LH, 32'h10, 32'h0, 1);
    resp_en = 1'b1;

    exp_res(32'h0, 1'b0, 0, 0, 1);
    run(4'b0000, 32'h40, 32'h0, 1);

    exp_res(32'h0, 1'b1, 32'd2, 32'h44, 1);
    run(4'b1001, 32'h44, 32'h0, 1);

    // Stray response while idle must not complete anything.
    @(posedge clk); #2; rresp = 32'h12345678; rvalid = 1'b1;
    @(posedge clk); #2; rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_after_stray", 64'(busy), 64'd0);

    // Reset while waiting for grant drops the request at once.
    gnt_en = 1'b0;
    @(posedge clk); #1; op = LW; addr = 32'h500; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("req_in_req0", 64'(bus.mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("req_async_clear", 64'(bus.mem_req), 64'd0);
    check("busy_async_clear", 64'(busy), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1; gnt_en = 1'b1;
    @(posedge clk); #2; rvalid = 1'b1;
    @(posedge clk); #2; rvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("busy_after_rst", 64'(busy), 64'd0);
    check("req_after_rst", 64'(bus.mem_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
